// File: rtl/ls_local_store.sv
// ls_local_store: quadword local store responder for the SPU load/store pipe.
// Accepts one load or store per cycle against a single-port 128-bit array and
// returns load data, tagged with its destination register, LAT cycles later.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   req_valid/req_we   request strobe, 1 = store / 0 = load
//   req_addr           byte address; the low 4 bits are ignored
//   req_wdata          store quadword
//   req_tag            load destination register tag
//   req_ready          high whenever out of reset
//   flush              kills every in-flight load and blocks acceptance
//   rsp_valid/_data/_tag  load response; data/tag hold while rsp_valid is low
//   busy, inflight_cnt    in-flight load indication and count
module ls_local_store #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DEPTH  = 2048,
    parameter int unsigned LAT    = 6,
    parameter int unsigned TAG_W  = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [127:0]      req_wdata,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              req_ready,
    input  logic              flush,
    output logic              rsp_valid,
    output logic [127:0]      rsp_data,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              busy,
    output logic [3:0]        inflight_cnt
);

    localparam int unsigned DATA_W = 128;
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = 4;

    logic                ready_q;
    logic [LAT-1:0]      vld_q, vld_d;
    logic [DATA_W-1:0]   data_q [LAT];
    logic [DATA_W-1:0]   data_d [LAT];
    logic [TAG_W-1:0]    tag_q  [LAT];
    logic [TAG_W-1:0]    tag_d  [LAT];
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   mem_q  [DEPTH];

    logic                accept_c;
    logic                ld_acc_c;
    logic                st_acc_c;
    logic [IDX_W-1:0]    idx_c;
    logic                unused_addr_bits;

    // Quadword index; the byte offset within the line is irrelevant.
    assign idx_c            = req_addr[4 +: IDX_W];
    assign unused_addr_bits = ^req_addr[3:0];

    assign accept_c = req_valid & ready_q & ~flush;
    assign ld_acc_c = accept_c & ~req_we;
    assign st_acc_c = accept_c &  req_we;

    // Load pipeline next state; payload only moves behind a valid entry so
    // the last stage holds its value between responses.
    always_comb begin
        vld_d  = '0;
        data_d = data_q;
        tag_d  = tag_q;
        cnt_d  = cnt_q;
        if (!flush) begin
            vld_d[0] = ld_acc_c;
            for (int unsigned k = 1; k < LAT; k++) begin
                vld_d[k] = vld_q[k-1];
                if (vld_q[k-1]) begin
                    data_d[k] = data_q[k-1];
                    tag_d[k]  = tag_q[k-1];
                end
            end
            cnt_d = cnt_q + CNT_W'(ld_acc_c) - CNT_W'(vld_q[LAT-1]);
        end else begin
            cnt_d = '0;
        end
        if (ld_acc_c) begin
            data_d[0] = mem_q[idx_c];
            tag_d[0]  = req_tag;
        end
    end

    // Pipeline, counter and ready registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
            vld_q   <= '0;
            cnt_q   <= '0;
            for (int unsigned k = 0; k < LAT; k++) begin
                data_q[k] <= '0;
                tag_q[k]  <= '0;
            end
        end else begin
            ready_q <= 1'b1;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
        end
    end

    // Storage array, deliberately not reset.
    always_ff @(posedge clk) begin
        if (st_acc_c) begin
            mem_q[idx_c] <= req_wdata;
        end
    end

    assign req_ready    = ready_q;
    // A response presented under flush is suppressed in the same cycle.
    assign rsp_valid    = vld_q[LAT-1] & ~flush;
    assign rsp_data     = data_q[LAT-1];
    assign rsp_tag      = tag_q[LAT-1];
    assign busy         = (cnt_q != '0);
    assign inflight_cnt = cnt_q;

endmodule

// File: tb/tb_ls_local_store.sv
// Testbench for ls_local_store: directed vector table, randomized traffic
// against a queue-based reference model, and a LAT=1 instance for wrap and
// accept/retire overlap.
module tb_ls_local_store;

    localparam int LAT = 6;
    localparam logic [127:0] PAT = 128'h0123456789ABCDEF0123456789ABCDEF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (LAT=6)
    logic         req_valid = 0, req_we = 0, flush = 0;
    logic [14:0]  req_addr = '0;
    logic [127:0] req_wdata = '0;
    logic [6:0]   req_tag = '0;
    logic         req_ready, rsp_valid, busy;
    logic [127:0] rsp_data;
    logic [6:0]   rsp_tag;
    logic [3:0]   inflight_cnt;

    // Second DUT (LAT=1)
    logic         d1_valid = 0, d1_we = 0, d1_flush = 0;
    logic [14:0]  d1_addr = '0;
    logic [127:0] d1_wdata = '0;
    logic [6:0]   d1_tag = '0;
    logic         d1_ready, d1_rvalid, d1_busy;
    logic [127:0] d1_rdata;
    logic [6:0]   d1_rtag;
    logic [3:0]   d1_cnt;

    ls_local_store #(.LAT(6)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
        .req_ready(req_ready), .flush(flush), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_tag(rsp_tag), .busy(busy),
        .inflight_cnt(inflight_cnt)
    );

    ls_local_store #(.LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(d1_valid), .req_we(d1_we),
        .req_addr(d1_addr), .req_wdata(d1_wdata), .req_tag(d1_tag),
        .req_ready(d1_ready), .flush(d1_flush), .rsp_valid(d1_rvalid),
        .rsp_data(d1_rdata), .rsp_tag(d1_rtag), .busy(d1_busy),
        .inflight_cnt(d1_cnt)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: memory by line index, pending loads with due cycle.
    typedef struct {
        int           due;
        logic [127:0] data;
        logic [6:0]   tag;
    } pend_t;
    pend_t        pq[$];
    logic [127:0] mem_m [int];
    logic [127:0] last_d = '0;
    logic [6:0]   last_t = '0;
    bit           ready_m = 0;

    typedef struct {
        logic         v, we;
        logic [14:0]  a;
        logic [127:0] wd;
        logic [6:0]   tg;
        logic         fl;
        logic         ev;
        logic [127:0] ed;
        logic [6:0]   et;
        logic [3:0]   ecnt;
    } vec_t;
    vec_t vt[$];

    function automatic vec_t mk(logic v, logic we, logic [14:0] a, logic [127:0] wd,
                                logic [6:0] tg, logic fl, logic ev, logic [127:0] ed,
                                logic [6:0] et, logic [3:0] ecnt);
        vec_t r;
        r.v = v; r.we = we; r.a = a; r.wd = wd; r.tg = tg; r.fl = fl;
        r.ev = ev; r.ed = ed; r.et = et; r.ecnt = ecnt;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    // One main-DUT cycle: drive at negedge, check, clock, update model.
    task automatic drive(input vec_t r, input bit tchk, input int row);
        bit due_now;
        bit acc;
        int idx;
        req_valid = r.v; req_we = r.we; req_addr = r.a;
        req_wdata = r.wd; req_tag = r.tg; flush = r.fl;
        #1;
        due_now = (pq.size() > 0) && (pq[0].due == cyc);
        if (due_now) begin
            last_d = pq[0].data;
            last_t = pq[0].tag;
        end
        chk("rsp_valid", rsp_valid, due_now && !r.fl);
        if (!r.fl) begin
            chk("rsp_data", rsp_data, last_d);
            chk("rsp_tag", rsp_tag, last_t);
        end
        chk("inflight_cnt", inflight_cnt, pq.size());
        chk("busy", busy, pq.size() != 0);
        chk("req_ready", req_ready, ready_m);
        if (tchk) begin
            chk($sformatf("tbl%0d_valid", row), rsp_valid, r.ev);
            chk($sformatf("tbl%0d_data", row), rsp_data, r.ed);
            chk($sformatf("tbl%0d_tag", row), rsp_tag, r.et);
            chk($sformatf("tbl%0d_cnt", row), inflight_cnt, r.ecnt);
        end
        @(posedge clk);
        acc = r.v && ready_m && !r.fl;
        idx = int'(r.a[14:4]);
        if (r.fl) pq.delete();
        else if (due_now) void'(pq.pop_front());
        if (acc && r.we) mem_m[idx] = r.wd;
        else if (acc) pq.push_back('{cyc + LAT, mem_m[idx], r.tg});
        ready_m = 1;
        cyc++;
        @(negedge clk);
    endtask

    // One LAT=1 DUT cycle with hand expectations.
    task automatic d1_step(input logic v, input logic we, input logic [14:0] a,
                           input logic [127:0] wd, input logic [6:0] tg, input logic fl,
                           input logic ev, input logic [127:0] ed, input logic [6:0] et,
                           input logic [3:0] ecnt, input string nm);
        d1_valid = v; d1_we = we; d1_addr = a; d1_wdata = wd; d1_tag = tg; d1_flush = fl;
        #1;
        chk({nm, "_valid"}, d1_rvalid, ev);
        if (ev) begin
            chk({nm, "_data"}, d1_rdata, ed);
            chk({nm, "_tag"}, d1_rtag, et);
        end
        chk({nm, "_cnt"}, d1_cnt, ecnt);
        chk({nm, "_busy"}, d1_busy, ecnt != 0);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] ed;
        logic [6:0]   et;
        logic         ev;
        logic [127:0] D1, D2;

        // Reset held 3 cycles with a load request present.
        rst_n = 0; req_valid = 1; req_we = 0; req_addr = 15'h0010; req_tag = 7'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_valid", rsp_valid, 1'b0);
            chk("rst_cnt", inflight_cnt, 4'd0);
            chk("rst_ready", req_ready, 1'b0);
            chk("rst_data", rsp_data, 128'd0);
        end
        rst_n = 1;
        #1;
        chk("rel_ready_pre", req_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("rel_ready_post", req_ready, 1'b1);
        chk("rel_cnt", inflight_cnt, 4'd0);
        req_valid = 0;
        ready_m = 1;
        cyc = 0;

        // Directed vector table.
        vt.push_back(mk(1, 1, 15'h0010, PAT, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 0, 15'h001F, 0, 5, 0, 0, 0, 0, 0));
        for (int j = 2; j <= 6; j++) vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, PAT, 5, 1));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, PAT, 5, 0));
        for (int i = 0; i < 8; i++)
            vt.push_back(mk(1, 1, 15'(i << 4), 128'(i), 0, 0, 0, PAT, 5, 0));
        for (int j = 17; j <= 31; j++) begin
            logic [3:0] c;
            ev = (j >= 23 && j <= 30);
            if (ev) begin ed = 128'(j - 23); et = 7'(j - 23); end
            else if (j < 23) begin ed = PAT; et = 7'd5; end
            else begin ed = 128'd7; et = 7'd7; end
            c = (j <= 23) ? 4'(j - 17) : (j <= 25) ? 4'd6 : 4'(31 - j);
            if (j <= 24) vt.push_back(mk(1, 0, 15'((j - 17) << 4), 0, 7'(j - 17), 0, ev, ed, et, c));
            else         vt.push_back(mk(0, 0, 0, 0, 0, 0, ev, ed, et, c));
        end
        for (int j = 32; j <= 34; j++)
            vt.push_back(mk(1, 0, 15'((j - 31) << 4), 0, 7'(j - 31), 0, 0, 128'd7, 7'd7, 4'(j - 32)));
        vt.push_back(mk(0, 0, 0, 0, 0, 1, 0, 128'd7, 7'd7, 3));
        for (int j = 36; j <= 42; j++) vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 128'd7, 7'd7, 0));
        vt.push_back(mk(1, 1, 15'h0040, {128{1'b1}}, 0, 1, 0, 128'd7, 7'd7, 0));
        vt.push_back(mk(1, 0, 15'h0048, 0, 9, 0, 0, 128'd7, 7'd7, 0));
        for (int j = 45; j <= 49; j++) vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 128'd7, 7'd7, 1));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 128'd4, 7'd9, 1));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 128'd4, 7'd9, 0));
        for (int i = 0; i < vt.size(); i++) drive(vt[i], 1, i);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 16; i++)
            drive(mk(1, 1, 15'(i << 4), {$urandom, $urandom, $urandom, $urandom}, 0, 0, 0, 0, 0, 0), 0, 0);
        for (int i = 0; i < 500; i++) begin
            int op;
            logic [14:0] a;
            op = int'($urandom_range(0, 9));
            a  = {7'd0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
            drive(mk(op <= 6, op >= 4 && op <= 6, a, {$urandom, $urandom, $urandom, $urandom},
                     7'($urandom_range(0, 127)), $urandom_range(0, 19) == 0, 0, 0, 0, 0), 0, 0);
        end
        for (int i = 0; i < LAT + 2; i++) drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0);

        // LAT=1 instance: wrap to line 2047, overlap of accept and retire, flush.
        D1 = 128'hDEADBEEF_00000000_CAFEF00D_12345678;
        D2 = 128'h0F0F0F0F_F0F0F0F0_A5A5A5A5_5A5A5A5A;
        d1_step(1, 1, 15'h7FF0, D1, 0, 0, 0, 0, 0, 0, "l1_st_hi");
        d1_step(1, 1, 15'h0005, D2, 0, 0, 0, 0, 0, 0, "l1_st_lo");
        d1_step(1, 0, 15'h7FFF, 0, 3, 0, 0, 0, 0, 0, "l1_ld_hi");
        d1_step(1, 0, 15'h0000, 0, 4, 0, 1, D1, 3, 1, "l1_rsp_hi");
        d1_step(0, 0, 0, 0, 0, 0, 1, D2, 4, 1, "l1_rsp_lo");
        d1_step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "l1_idle");
        chk("l1_hold_data", d1_rdata, D2);
        d1_step(1, 0, 15'h7FF0, 0, 6, 0, 0, 0, 0, 0, "l1_ld_f");
        d1_step(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, "l1_flush");
        d1_step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "l1_post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ls_local_store.md
Name: ls_local_store

Overview:
- Local store responder for the SPU load/store pipe. Consumes the 15-bit byte addresses produced for lqa/lqd/stqa/stqd.
- Performs quadword (128-bit) reads and writes on a single-port storage array.
- Returns load data after a fixed pipeline latency, tagged with the destination register, for writeback.
- Sits between address generation in the odd pipe and the register-file writeback arbiter.

Parameters:
- ADDR_W, 15, byte address width (32 KB local store).
- DEPTH, 2048, number of quadword lines (2^(ADDR_W-4)).
- LAT, 6, load latency in cycles from request acceptance to rsp_valid; legal range 1..8.
- TAG_W, 7, destination register tag width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present this cycle
- req_we  input  1  1 = store (stqa/stqd), 0 = load (lqa/lqd)
- req_addr  input  15  byte address; bits [11:14] (low 4) ignored, quadword index = addr[0:10]
- req_wdata  input  128  store data, bit 0 = MSB
- req_tag  input  7  load destination register; ignored for stores
- req_ready  output  1  request accepted when req_valid & req_ready
- flush  input  1  kill all in-flight loads (branch redirect)
- rsp_valid  output  1  load data valid
- rsp_data  output  128  load quadword
- rsp_tag  output  7  tag of returning load
- busy  output  1  any load in flight
- inflight_cnt  output  4  number of loads in flight, 0..LAT

Behaviour:
- Reset (async, rst_n low): all pipeline valid bits cleared.
  - rsp_valid=0, rsp_data=0, rsp_tag=0, busy=0, inflight_cnt=0, req_ready=0.
  - req_ready goes to 1 on the first clk edge after rst_n deasserts.
  - Array contents are not reset; they are undefined until written.
- Acceptance: one request per cycle max; accept = req_valid & req_ready & ~flush.
  - req_ready is 1 whenever out of reset; there is no backpressure from the response side.
- Store: the array line addr[0:10] is written with req_wdata at the accepting edge. No response is generated, and inflight_cnt is unaffected.
- Load: the line is read at the accepting edge and {data, tag} enters stage 1 of a LAT-deep shift pipeline.
  - The result appears at stage LAT with rsp_valid=1 exactly LAT cycles after acceptance, held for one cycle.
- Ordering: a load accepted in any cycle after a store to the same line returns the stored data. There is no same-cycle conflict because only one request is accepted per cycle.
- Back-to-back loads every cycle: rsp_valid is continuous, in order, one per cycle.
- Flush:
  - Clears every pipeline valid bit at the edge.
  - A response that would have been presented in the cycle flush is high is suppressed (rsp_valid forced 0 combinationally, registered clear).
  - A request presented with flush high is not accepted. A store coincident with flush is dropped (no write).
- inflight_cnt is the population count of pipeline valid bits.
  - It increments on a load accept and decrements when the stage-LAT entry retires.
  - If both happen in the same cycle it is unchanged. It is 0 after flush.
- busy = (inflight_cnt != 0).
- Address wrap: indices are taken modulo DEPTH; there is no out-of-range error.
- rsp_data and rsp_tag hold their last values when rsp_valid=0.
- Reset asserted mid-operation aborts all in-flight loads immediately. A store whose edge coincides with reset assertion is not guaranteed.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with req_valid=1 -> rsp_valid=0, inflight_cnt=0, req_ready=0; req_ready=1 one cycle after release.
- Store then load: store addr=0x0010, data=0x0123..CDEF (128-bit pattern); next cycle load addr=0x001F, tag=5 -> rsp_valid exactly 6 cycles later, rsp_data=pattern, rsp_tag=5 (low nibble ignored).
- Streaming: 8 consecutive loads to lines 0..7, tags 0..7, after preloading line i with value i -> rsp_valid high for 8 consecutive cycles, data/tag 0..7 in order; inflight_cnt saturates at 6.
- Flush: issue loads with tags 1,2,3 on consecutive cycles, assert flush on the cycle after tag 3 -> no rsp_valid for any of them; inflight_cnt=0 and busy=0 the next cycle.
- Flush coincident with store: store 0xFFFF...F to line 4 while flush=1, then load line 4 -> returns the prior contents of line 4.
- Wrap and LAT=1 build: load addr=0x7FF0 (line 2047) -> rsp at the next cycle. Simultaneous accept and retire -> inflight_cnt holds at 1.
